// File: rtl/feature_quantizer_packer.sv
// Quantizes signed raw features to 2-bit codes against three thresholds and packs
// N_FEATURES codes per vector, with one closed vector allowed to wait behind m_data.
module feature_quantizer_packer #(
    parameter int                          N_FEATURES = 16,
    parameter int                          IN_WIDTH   = 8,
    parameter logic signed [IN_WIDTH-1:0]  TH0        = IN_WIDTH'(-32),
    parameter logic signed [IN_WIDTH-1:0]  TH1        = IN_WIDTH'(0),
    parameter logic signed [IN_WIDTH-1:0]  TH2        = IN_WIDTH'(32)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [IN_WIDTH-1:0]       s_data,
    input  logic                      s_last,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [2*N_FEATURES-1:0]   m_data,
    output logic                      err_len
);

    localparam int                CW       = $clog2(N_FEATURES);
    localparam int                VW       = 2 * N_FEATURES;
    localparam logic [CW-1:0]     LAST_IDX = CW'(N_FEATURES - 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [VW-1:0]    shadow_q, shadow_d;
    logic [VW-1:0]    mdata_q, mdata_d;
    logic             pend_q, pend_d;
    logic             err_q, err_d;

    logic             ge0, ge1, ge2;
    logic [1:0]       code;
    logic             accept;
    logic             at_end;
    logic             close;
    logic [VW-1:0]    shadow_wr;

    assign ge0  = $signed(s_data) >= TH0;
    assign ge1  = $signed(s_data) >= TH1;
    assign ge2  = $signed(s_data) >= TH2;
    assign code = {1'b0, ge0} + {1'b0, ge1} + {1'b0, ge2};

    // pend_q is registered, so s_ready never sees m_ready combinationally
    assign s_ready = ~pend_q;
    assign accept  = s_valid & ~pend_q;
    assign at_end  = (cnt_q == LAST_IDX);
    assign close   = accept & (at_end | s_last);

    // Shadow vector with the incoming code merged into slot cnt
    genvar gi;
    generate
        for (gi = 0; gi < N_FEATURES; gi++) begin : g_slot
            assign shadow_wr[2*gi +: 2] = (cnt_q == CW'(gi)) ? code : shadow_q[2*gi +: 2];
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        mdata_d  = mdata_q;
        pend_d   = pend_q;
        err_d    = close & ~(s_last & at_end);

        if (accept) begin
            if (close) begin
                cnt_d    = '0;
                shadow_d = '0;
            end else begin
                cnt_d    = cnt_q + CW'(1);
                shadow_d = shadow_wr;
            end
        end

        case (state_q)
            FILL: begin
                if (close) begin
                    mdata_d = shadow_wr;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (pend_q) begin
                    // A closed vector is parked in the shadow; hand it over on release
                    if (m_ready) begin
                        mdata_d  = shadow_q;
                        shadow_d = '0;
                        pend_d   = 1'b0;
                    end
                end else if (close) begin
                    if (m_ready) begin
                        mdata_d = shadow_wr;
                    end else begin
                        pend_d   = 1'b1;
                        shadow_d = shadow_wr;
                    end
                end else if (m_ready) begin
                    state_d = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FILL;
            cnt_q    <= '0;
            shadow_q <= '0;
            mdata_q  <= '0;
            pend_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            mdata_q  <= mdata_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
        end
    end

    assign m_valid = (state_q == HOLD);
    assign m_data  = mdata_q;
    assign err_len = err_q;

endmodule
